// File: rtl/note_highway.sv
// note_highway: per-lane falling-note engine with press scoring and a pixel overlay.
// Latency: colour and hit/miss/overflow pulses are registered, 1 cycle after the inputs.
// Backpressure: none; a spawn into an occupied slot is dropped and flagged on overflow.
module note_highway #(
    parameter int LANES       = 4,
    parameter int SLOTS       = 8,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int NOTE_W      = 50,
    parameter int NOTE_H      = 20,
    parameter int LANE_X0     = 170,
    parameter int LANE_PITCH  = 80,
    parameter int SPEED       = 2,
    parameter int HIT_Y       = 400,
    parameter int HIT_WIN     = 16,
    parameter logic [12*LANES-1:0] LANE_COLORS = 48'hFF0_00F_0F0_F00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             spawn_tick,
    input  logic [LANES-1:0] spawn_mask,
    input  logic [LANES-1:0] key,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic             active,
    input  logic [11:0]      bg_color,
    output logic [11:0]      color_out,
    output logic [LANES-1:0] hit,
    output logic [LANES-1:0] miss,
    output logic             overflow,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PW-1:0]    LAST_SLOT = PW'(SLOTS - 1);
    localparam logic [SLOTS-1:0] ONE_S     = SLOTS'(1);
    localparam logic [10:0]      WIN_LO    = 11'(HIT_Y - HIT_WIN);
    localparam logic [10:0]      WIN_HI    = 11'(HIT_Y + HIT_WIN);

    logic [SLOTS-1:0] valid  [LANES];
    logic [9:0]       pos    [LANES][SLOTS];
    logic [PW-1:0]    wr_ptr [LANES];
    logic [LANES-1:0] key_q;

    logic [LANES-1:0] press, hit_any, miss_any, spawn_ok, spawn_ovf;
    logic [SLOTS-1:0] cand   [LANES];
    logic [SLOTS-1:0] hit_oh [LANES];
    logic [SLOTS-1:0] exits  [LANES];
    logic [10:0]      moved  [LANES][SLOTS];

    logic [LANES-1:0] in_lane, note_px;
    logic [10:0]      xl, yl;
    logic [11:0]      px_nxt;
    logic [16:0]      hit_sum, miss_sum;

    function automatic logic [16:0] popcnt(input logic [LANES-1:0] v);
        popcnt = '0;
        for (int k = 0; k < LANES; k++) popcnt = popcnt + 17'(v[k]);
    endfunction

    assign press = key & ~key_q;
    assign xl    = {1'b0, x};
    assign yl    = {2'b0, y};

    // All decisions use start-of-cycle slot state, so hit, move and spawn can coincide.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            for (int s = 0; s < SLOTS; s++) begin
                moved[i][s] = {1'b0, pos[i][s]} + 11'(SPEED);
                cand[i][s]  = valid[i][s] && ({1'b0, pos[i][s]} >= WIN_LO)
                                          && ({1'b0, pos[i][s]} <= WIN_HI);
            end
            // Isolate the lowest-index candidate.
            hit_oh[i] = cand[i] & (~cand[i] + ONE_S) & {SLOTS{press[i]}};
            for (int s = 0; s < SLOTS; s++) begin
                exits[i][s] = frame_tick && valid[i][s] && !hit_oh[i][s]
                              && (moved[i][s] >= 11'(HEIGHT));
            end
            hit_any[i]   = |hit_oh[i];
            miss_any[i]  = |exits[i];
            spawn_ok[i]  = spawn_tick && spawn_mask[i] && !valid[i][wr_ptr[i]];
            spawn_ovf[i] = spawn_tick && spawn_mask[i] &&  valid[i][wr_ptr[i]];
        end
    end

    always_comb begin
        in_lane = '0;
        note_px = '0;
        for (int i = 0; i < LANES; i++) begin
            in_lane[i] = (xl >= 11'(LANE_X0 + i*LANE_PITCH))
                      && (xl <  11'(LANE_X0 + i*LANE_PITCH + NOTE_W))
                      && (xl <  11'(WIDTH));
            for (int s = 0; s < SLOTS; s++) begin
                if (in_lane[i] && valid[i][s] && (yl >= {1'b0, pos[i][s]})
                    && (yl < {1'b0, pos[i][s]} + 11'(NOTE_H)))
                    note_px[i] = 1'b1;
            end
        end
        px_nxt = bg_color;
        if (yl == 11'(HIT_Y) && |in_lane) px_nxt = 12'hFFF;
        for (int i = LANES-1; i >= 0; i--) begin
            if (note_px[i]) px_nxt = LANE_COLORS[12*i +: 12];
        end
        if (!active) px_nxt = 12'h000;
    end

    assign hit_sum  = {1'b0, hit_count}  + popcnt(hit_any);
    assign miss_sum = {1'b0, miss_count} + popcnt(miss_any);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                valid[i]  <= '0;
                wr_ptr[i] <= '0;
                for (int s = 0; s < SLOTS; s++) pos[i][s] <= '0;
            end
            key_q      <= '0;
            color_out  <= '0;
            hit        <= '0;
            miss       <= '0;
            overflow   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            key_q <= key;
            for (int i = 0; i < LANES; i++) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (spawn_ok[i] && (wr_ptr[i] == PW'(s))) begin
                        valid[i][s] <= 1'b1;
                        pos[i][s]   <= '0;
                    end else if (hit_oh[i][s] || exits[i][s]) begin
                        valid[i][s] <= 1'b0;
                    end else if (frame_tick && valid[i][s]) begin
                        pos[i][s] <= moved[i][s][9:0];
                    end
                end
                if (spawn_ok[i])
                    wr_ptr[i] <= (wr_ptr[i] == LAST_SLOT) ? '0 : wr_ptr[i] + PW'(1);
            end
            color_out  <= px_nxt;
            hit        <= hit_any;
            miss       <= miss_any;
            overflow   <= |spawn_ovf;
            hit_count  <= (hit_sum  > 17'hFFFF) ? 16'hFFFF : hit_sum[15:0];
            miss_count <= (miss_sum > 17'hFFFF) ? 16'hFFFF : miss_sum[15:0];
        end
    end

endmodule

// File: tb/tb_note_highway.sv
// tb_note_highway: directed scenarios plus random traffic against a per-note reference model.
// Latency: every cycle's registered outputs are compared one cycle after the inputs.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_note_highway;
    localparam int L = 4;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         reset, frame_tick, spawn_tick, active;
    logic [L-1:0] spawn_mask, key;
    logic [9:0]   x;
    logic [8:0]   y;
    logic [11:0]  bg_color;
    logic [11:0]  color_out;
    logic [L-1:0] hit, miss;
    logic         overflow;
    logic [15:0]  hit_count, miss_count;

    always #5 clk = ~clk;

    note_highway dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .spawn_tick(spawn_tick),
        .spawn_mask(spawn_mask), .key(key), .x(x), .y(y), .active(active),
        .bg_color(bg_color), .color_out(color_out), .hit(hit), .miss(miss),
        .overflow(overflow), .hit_count(hit_count), .miss_count(miss_count)
    );

    // Reference model: one record per note slot, plain integer positions.
    bit           mv [L][S];
    int           mp [L][S];
    int           mw [L];
    bit   [L-1:0] mkq;
    logic [11:0]  e_color;
    logic [L-1:0] e_hit, e_miss;
    logic         e_ovf;
    int           e_hc, e_mc;
    logic [11:0]  lane_col [L] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_px();
        int xi = int'(x);
        int yi = int'(y);
        if (!active) return 12'h000;
        for (int i = 0; i < L; i++) begin
            if (xi >= 170 + 80*i && xi < 220 + 80*i)
                for (int s = 0; s < S; s++)
                    if (mv[i][s] && yi >= mp[i][s] && yi < mp[i][s] + 20) return lane_col[i];
        end
        if (yi == 400)
            for (int i = 0; i < L; i++)
                if (xi >= 170 + 80*i && xi < 220 + 80*i) return 12'hFFF;
        return bg_color;
    endfunction

    task automatic model_cycle();
        bit nv [L][S];
        int np [L][S];
        int hs;
        logic [L-1:0] hl = '0;
        logic [L-1:0] ml = '0;
        logic ov = 1'b0;
        logic [11:0] c = model_px();
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                mw[i] = 0;
                for (int s = 0; s < S; s++) begin mv[i][s] = 0; mp[i][s] = 0; end
            end
            mkq = '0; e_color = '0; e_hit = '0; e_miss = '0; e_ovf = 0; e_hc = 0; e_mc = 0;
            return;
        end
        nv = mv;
        np = mp;
        for (int i = 0; i < L; i++) begin
            hs = -1;
            if (key[i] && !mkq[i])
                for (int s = 0; s < S; s++)
                    if (hs < 0 && mv[i][s] && mp[i][s] >= 384 && mp[i][s] <= 416) hs = s;
            if (hs >= 0) begin nv[i][hs] = 0; hl[i] = 1'b1; end
            if (frame_tick)
                for (int s = 0; s < S; s++)
                    if (mv[i][s] && s != hs) begin
                        if (mp[i][s] + 2 >= 480) begin nv[i][s] = 0; ml[i] = 1'b1; end
                        else np[i][s] = mp[i][s] + 2;
                    end
            if (spawn_tick && spawn_mask[i]) begin
                if (!mv[i][mw[i]]) begin
                    nv[i][mw[i]] = 1; np[i][mw[i]] = 0; mw[i] = (mw[i] + 1) % S;
                end else ov = 1'b1;
            end
        end
        mv = nv;
        mp = np;
        mkq = key;
        e_color = c; e_hit = hl; e_miss = ml; e_ovf = ov;
        e_hc = (e_hc + $countones(hl) > 65535) ? 65535 : e_hc + $countones(hl);
        e_mc = (e_mc + $countones(ml) > 65535) ? 65535 : e_mc + $countones(ml);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        chk("color_out",  32'(color_out),  32'(e_color));
        chk("hit",        32'(hit),        32'(e_hit));
        chk("miss",       32'(miss),       32'(e_miss));
        chk("overflow",   32'(overflow),   32'(e_ovf));
        chk("hit_count",  32'(hit_count),  32'(e_hc));
        chk("miss_count", 32'(miss_count), 32'(e_mc));
    endtask

    task automatic frames(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic spawn(input logic [L-1:0] m);
        spawn_tick = 1'b1; spawn_mask = m;
        step();
        spawn_tick = 1'b0; spawn_mask = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic probe(input int px, input int py, input logic act,
                         input logic [11:0] exp, input string tag);
        x = 10'(px); y = 9'(py); active = act;
        step();
        chk(tag, 32'(color_out), 32'(exp));
    endtask

    initial begin
        reset = 0; frame_tick = 0; spawn_tick = 0; spawn_mask = '0; key = '0;
        x = '0; y = '0; active = 0; bg_color = 12'h123;
        do_reset();

        // Reset with notes on screen, pixel pointing at a note during reset.
        spawn(4'b1111);
        frames(10);
        x = 10'd170; y = 9'd25; active = 1'b1;
        do_reset();
        chk("rst_color", 32'(color_out), 32'h000);
        chk("rst_hits",  32'(hit_count), 32'h0);
        probe(170, 25, 1'b1, 12'h123, "rst_notes_gone");

        // Scroll to the hit line and probe the rectangle edges.
        spawn(4'b0001);
        frames(200);
        probe(170, 405, 1'b1, 12'hF00, "px_note");
        probe(169, 405, 1'b1, 12'h123, "px_left_edge");
        probe(219, 419, 1'b1, 12'hF00, "px_br_corner");
        probe(220, 405, 1'b1, 12'h123, "px_right_edge");
        probe(170, 420, 1'b1, 12'h123, "px_bottom_edge");
        probe(260, 400, 1'b1, 12'hFFF, "px_hit_line");
        probe(100, 400, 1'b1, 12'h123, "px_line_outside");
        probe(170, 405, 1'b0, 12'h000, "px_inactive");

        // Hit at 390, then a press with nothing to hit, then a held key.
        do_reset();
        spawn(4'b0001);
        frames(195);
        key = 4'b0001; step();
        chk("hit_pulse", 32'(hit), 32'h1);
        chk("hit_cnt1",  32'(hit_count), 32'h1);
        key = 4'b0000; step();
        key = 4'b0001; step();
        chk("no_note_press", 32'(hit), 32'h0);
        repeat (3) step();
        chk("held_key_cnt", 32'(hit_count), 32'h1);
        key = 4'b0000;
        probe(170, 395, 1'b1, 12'h123, "hit_cleared");

        // Leaving the screen from 478.
        do_reset();
        spawn(4'b0001);
        frames(239);
        frames(1);
        chk("miss_pulse", 32'(miss), 32'h1);
        chk("miss_cnt1",  32'(miss_count), 32'h1);
        probe(170, 479, 1'b1, 12'h123, "miss_cleared");

        // Nine spawns into eight slots, then count the survivors by hitting them.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            spawn(4'b0010);
            if (k == 7) chk("ovf_8th", 32'(overflow), 32'h0);
        end
        chk("ovf_9th", 32'(overflow), 32'h1);
        frames(200);
        for (int k = 0; k < 9; k++) begin
            key = 4'b0010; step();
            key = 4'b0000; step();
        end
        chk("eight_valid", 32'(hit_count), 32'h8);

        // Hit, move and spawn in one cycle, then saturation.
        do_reset();
        spawn(4'b0001);
        frames(200);
        frame_tick = 1'b1; spawn_tick = 1'b1; spawn_mask = 4'b0001; key = 4'b0001;
        step();
        frame_tick = 1'b0; spawn_tick = 1'b0; spawn_mask = '0;
        chk("combo_hit",  32'(hit),  32'h1);
        chk("combo_miss", 32'(miss), 32'h0);
        probe(170, 5,   1'b1, 12'hF00, "combo_new_note");
        probe(170, 405, 1'b1, 12'h123, "combo_old_gone");
        key = 4'b0000; step();
        force dut.hit_count = 16'hFFFF;
        #1;
        release dut.hit_count;
        e_hc = 65535;
        frames(200);
        key = 4'b0001; step();
        chk("sat_hit",   32'(hit), 32'h1);
        chk("sat_count", 32'(hit_count), 32'hFFFF);
        key = 4'b0000;

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 999) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            spawn_tick = ($urandom_range(0, 29) == 0);
            spawn_mask = 4'($urandom);
            for (int l = 0; l < L; l++)
                if ($urandom_range(0, 7) == 0) key[l] = ~key[l];
            active   = ($urandom_range(0, 7) != 0);
            bg_color = 12'($urandom);
            if ($urandom_range(0, 1) == 1)
                x = 10'(170 + 80*int'($urandom_range(0, 3)) + int'($urandom_range(0, 60)) - 5);
            else
                x = 10'($urandom_range(0, 639));
            y = 9'($urandom_range(0, 479));
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
